// File: rtl/core_imem_if.sv
// Bus bundle between the DMA/pixel-address side and the core_imem pixel buffer.
interface core_imem_if;
  logic        I_IM_CLEAR;
  logic        I_IM_WR_EN;
  logic [31:0] I_IM_HRDATA;
  logic [7:0]  I_IM_WR_ADDR0;
  logic [7:0]  I_IM_WR_ADDR1;
  logic [7:0]  I_IM_WR_ADDR2;
  logic [7:0]  I_IM_WR_ADDR3;
  logic        I_IM_PAD;
  logic        I_IM_RD_EN;
  logic [7:0]  I_IM_RD_ADDRR;
  logic [7:0]  I_IM_RD_ADDRG;
  logic [7:0]  I_IM_RD_ADDRB;
  logic [23:0] O_IM_RD_DATA;
  logic        O_IM_RD_VALID;
  logic        O_IM_FULL;
  logic        O_IM_EMPTY;
  logic        O_IM_OVF;
  logic        O_IM_UNF;

  modport master (
    output I_IM_CLEAR, I_IM_WR_EN, I_IM_HRDATA,
    output I_IM_WR_ADDR0, I_IM_WR_ADDR1, I_IM_WR_ADDR2, I_IM_WR_ADDR3,
    output I_IM_PAD, I_IM_RD_EN, I_IM_RD_ADDRR, I_IM_RD_ADDRG, I_IM_RD_ADDRB,
    input  O_IM_RD_DATA, O_IM_RD_VALID, O_IM_FULL, O_IM_EMPTY, O_IM_OVF, O_IM_UNF
  );

  modport slave (
    input  I_IM_CLEAR, I_IM_WR_EN, I_IM_HRDATA,
    input  I_IM_WR_ADDR0, I_IM_WR_ADDR1, I_IM_WR_ADDR2, I_IM_WR_ADDR3,
    input  I_IM_PAD, I_IM_RD_EN, I_IM_RD_ADDRR, I_IM_RD_ADDRG, I_IM_RD_ADDRB,
    output O_IM_RD_DATA, O_IM_RD_VALID, O_IM_FULL, O_IM_EMPTY, O_IM_OVF, O_IM_UNF
  );
endinterface

// File: rtl/core_imem.sv
// Input pixel buffer: fills one 8x8 RGB block from 32-bit DMA beats, then
// drains it one 24-bit pixel per read, flagging rejected writes/reads.
module core_imem #(
  parameter int P_DEPTH        = 256,
  parameter int P_BLOCK_BEATS  = 48,
  parameter int P_BLOCK_PIXELS = 64
) (
  input logic I_IM_HCLK,
  input logic I_IM_RESET,
  core_imem_if.slave bus
);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  localparam logic [5:0] BEAT_LAST = 6'(P_BLOCK_BEATS - 1);
  localparam logic [6:0] PIX_LAST  = 7'(P_BLOCK_PIXELS - 1);

  logic [7:0]  mem [P_DEPTH];

  state_t      state, state_n;
  logic [5:0]  beat_cnt, beat_n;
  logic [6:0]  pix_cnt, pix_n;
  logic [23:0] rd_data, data_n;
  logic        rd_valid, valid_n;
  logic        full, full_n;
  logic        empty, empty_n;
  logic        ovf, ovf_n;
  logic        unf, unf_n;
  logic        wr_accept;
  logic [7:0]  lane0, lane1, lane2, lane3;

  assign lane0 = bus.I_IM_PAD ? 8'h00 : bus.I_IM_HRDATA[7:0];
  assign lane1 = bus.I_IM_PAD ? 8'h00 : bus.I_IM_HRDATA[15:8];
  assign lane2 = bus.I_IM_PAD ? 8'h00 : bus.I_IM_HRDATA[23:16];
  assign lane3 = bus.I_IM_PAD ? 8'h00 : bus.I_IM_HRDATA[31:24];

  always_ff @(posedge I_IM_HCLK) begin
    if (I_IM_RESET) begin
      state    <= S_FILL;
      beat_cnt <= '0;
      pix_cnt  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_n;
      pix_cnt  <= pix_n;
      rd_data  <= data_n;
      rd_valid <= valid_n;
      full     <= full_n;
      empty    <= empty_n;
      ovf      <= ovf_n;
      unf      <= unf_n;
    end
  end

  // Lanes are written in ascending order so a duplicate address keeps the highest lane.
  always_ff @(posedge I_IM_HCLK) begin
    if (!I_IM_RESET && wr_accept) begin
      mem[bus.I_IM_WR_ADDR0] <= lane0;
      mem[bus.I_IM_WR_ADDR1] <= lane1;
      mem[bus.I_IM_WR_ADDR2] <= lane2;
      mem[bus.I_IM_WR_ADDR3] <= lane3;
    end
  end

  always_comb begin
    state_n   = state;
    beat_n    = beat_cnt;
    pix_n     = pix_cnt;
    data_n    = rd_data;
    valid_n   = 1'b0;
    full_n    = full;
    ovf_n     = ovf;
    unf_n     = unf;
    wr_accept = 1'b0;
    if (bus.I_IM_CLEAR) begin
      state_n = S_FILL;
      beat_n  = '0;
      pix_n   = '0;
      data_n  = '0;
      full_n  = 1'b0;
      ovf_n   = 1'b0;
      unf_n   = 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (bus.I_IM_RD_EN) unf_n = 1'b1;
          if (bus.I_IM_WR_EN) begin
            wr_accept = 1'b1;
            if (beat_cnt == BEAT_LAST) begin
              state_n = S_DRAIN;
              beat_n  = '0;
              full_n  = 1'b1;
            end else begin
              beat_n = beat_cnt + 6'd1;
            end
          end
        end
        S_DRAIN: begin
          if (bus.I_IM_WR_EN) ovf_n = 1'b1;
          if (bus.I_IM_RD_EN) begin
            data_n  = {mem[bus.I_IM_RD_ADDRR], mem[bus.I_IM_RD_ADDRG], mem[bus.I_IM_RD_ADDRB]};
            valid_n = 1'b1;
            if (pix_cnt == PIX_LAST) begin
              state_n = S_FILL;
              pix_n   = '0;
              full_n  = 1'b0;
            end else begin
              pix_n = pix_cnt + 7'd1;
            end
          end
        end
      endcase
    end
    empty_n = (state_n == S_FILL) && (beat_n == 6'd0);
  end

  assign bus.O_IM_RD_DATA  = rd_data;
  assign bus.O_IM_RD_VALID = rd_valid;
  assign bus.O_IM_FULL     = full;
  assign bus.O_IM_EMPTY    = empty;
  assign bus.O_IM_OVF      = ovf;
  assign bus.O_IM_UNF      = unf;

endmodule

// File: tb/tb_core_imem.sv
// Self-checking bench for core_imem: behavioural block-buffer model plus
// directed pattern checks followed by randomized traffic.
module tb_core_imem;

  logic clk = 1'b0;
  logic reset;
  core_imem_if bus();

  core_imem dut (
    .I_IM_HCLK (clk),
    .I_IM_RESET(reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: a byte array plus "draining" flag and beat/pixel tallies.
  logic [7:0]  m_mem [256];
  bit          model_on = 1'b0;
  bit          m_drain = 1'b0;
  int          m_beats = 0;
  int          m_pixels = 0;
  logic [23:0] exp_data = '0;
  bit          exp_valid = 1'b0;
  bit          exp_full = 1'b0;
  bit          exp_empty = 1'b1;
  bit          exp_ovf = 1'b0;
  bit          exp_unf = 1'b0;
  logic [7:0]  lane_addr [4];

  always @(posedge clk) begin
    if (reset || bus.I_IM_CLEAR) begin
      if (reset) model_on = 1'b1;
      m_drain   = 1'b0;
      m_beats   = 0;
      m_pixels  = 0;
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (!m_drain) begin
        if (bus.I_IM_RD_EN) exp_unf = 1'b1;
        if (bus.I_IM_WR_EN) begin
          lane_addr = '{bus.I_IM_WR_ADDR0, bus.I_IM_WR_ADDR1, bus.I_IM_WR_ADDR2, bus.I_IM_WR_ADDR3};
          for (int l = 0; l < 4; l++)
            m_mem[lane_addr[l]] = bus.I_IM_PAD ? 8'h00 : bus.I_IM_HRDATA[8*l +: 8];
          m_beats++;
          if (m_beats == 48) begin
            m_drain = 1'b1;
            m_beats = 0;
          end
        end
      end else begin
        if (bus.I_IM_WR_EN) exp_ovf = 1'b1;
        if (bus.I_IM_RD_EN) begin
          exp_data  = {m_mem[bus.I_IM_RD_ADDRR], m_mem[bus.I_IM_RD_ADDRG], m_mem[bus.I_IM_RD_ADDRB]};
          exp_valid = 1'b1;
          m_pixels++;
          if (m_pixels == 64) begin
            m_drain  = 1'b0;
            m_pixels = 0;
          end
        end
      end
    end
    exp_full  = m_drain;
    exp_empty = !m_drain && (m_beats == 0);
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check_output("rd_data",  32'(bus.O_IM_RD_DATA),  32'(exp_data));
      check_output("rd_valid", 32'(bus.O_IM_RD_VALID), 32'(exp_valid));
      check_output("full",     32'(bus.O_IM_FULL),     32'(exp_full));
      check_output("empty",    32'(bus.O_IM_EMPTY),    32'(exp_empty));
      check_output("ovf",      32'(bus.O_IM_OVF),      32'(exp_ovf));
      check_output("unf",      32'(bus.O_IM_UNF),      32'(exp_unf));
    end
  end

  // Drives one cycle of inputs, waits for the following falling edge, then idles the strobes.
  task automatic apply_stimulus(input bit we, input bit pad, input logic [31:0] data,
                                input logic [7:0] a0, input logic [7:0] a1,
                                input logic [7:0] a2, input logic [7:0] a3,
                                input bit re, input logic [7:0] r, input logic [7:0] g,
                                input logic [7:0] b, input bit clr);
    bus.I_IM_WR_EN    = we;
    bus.I_IM_PAD      = pad;
    bus.I_IM_HRDATA   = data;
    bus.I_IM_WR_ADDR0 = a0;
    bus.I_IM_WR_ADDR1 = a1;
    bus.I_IM_WR_ADDR2 = a2;
    bus.I_IM_WR_ADDR3 = a3;
    bus.I_IM_RD_EN    = re;
    bus.I_IM_RD_ADDRR = r;
    bus.I_IM_RD_ADDRG = g;
    bus.I_IM_RD_ADDRB = b;
    bus.I_IM_CLEAR    = clr;
    @(negedge clk);
    bus.I_IM_WR_EN = 1'b0;
    bus.I_IM_PAD   = 1'b0;
    bus.I_IM_RD_EN = 1'b0;
    bus.I_IM_CLEAR = 1'b0;
  endtask

  task automatic write_beat(input logic [31:0] data, input logic [7:0] base, input bit pad);
    apply_stimulus(1'b1, pad, data, base, base + 8'd1, base + 8'd2, base + 8'd3,
                   1'b0, 8'h0, 8'h0, 8'h0, 1'b0);
  endtask

  task automatic read_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    apply_stimulus(1'b0, 1'b0, 32'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1, r, g, b, 1'b0);
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 1'b0, 32'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b0);
  endtask

  initial begin
    logic [7:0]  base;
    logic [31:0] data;
    reset = 1'b1;
    bus.I_IM_CLEAR = 1'b0;  bus.I_IM_WR_EN = 1'b0;  bus.I_IM_PAD = 1'b0;
    bus.I_IM_HRDATA = '0;   bus.I_IM_RD_EN = 1'b0;
    bus.I_IM_WR_ADDR0 = '0; bus.I_IM_WR_ADDR1 = '0; bus.I_IM_WR_ADDR2 = '0; bus.I_IM_WR_ADDR3 = '0;
    bus.I_IM_RD_ADDRR = '0; bus.I_IM_RD_ADDRG = '0; bus.I_IM_RD_ADDRB = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_cycle();
    idle_cycle();
    check_output("lit_reset_full",  32'(bus.O_IM_FULL),     32'd0);
    check_output("lit_reset_empty", 32'(bus.O_IM_EMPTY),    32'd1);
    check_output("lit_reset_valid", 32'(bus.O_IM_RD_VALID), 32'd0);
    check_output("lit_reset_data",  32'(bus.O_IM_RD_DATA),  32'd0);
    check_output("lit_reset_ovf",   32'(bus.O_IM_OVF),      32'd0);
    check_output("lit_reset_unf",   32'(bus.O_IM_UNF),      32'd0);

    // Block of incrementing bytes; beat 5 is a pad beat carrying all-ones data.
    for (int k = 0; k < 48; k++) begin
      base = 8'(4 * k);
      data = {base + 8'd3, base + 8'd2, base + 8'd1, base};
      if (k == 5) write_beat(32'hFFFF_FFFF, base, 1'b1);
      else        write_beat(data, base, 1'b0);
      if (k == 0)  check_output("lit_empty_after_first", 32'(bus.O_IM_EMPTY), 32'd0);
      if (k == 46) check_output("lit_full_before_last",  32'(bus.O_IM_FULL),  32'd0);
    end
    check_output("lit_full_after_48", 32'(bus.O_IM_FULL), 32'd1);

    write_beat(32'hDEAD_BEEF, 8'h00, 1'b0);
    check_output("lit_ovf", 32'(bus.O_IM_OVF), 32'd1);

    for (int p = 0; p < 64; p++) begin
      base = 8'(3 * p);
      read_pixel(base, base + 8'd1, base + 8'd2);
      if (p == 0) check_output("lit_pix0",  32'(bus.O_IM_RD_DATA), 32'h000102);
      if (p == 6) check_output("lit_pix6",  32'(bus.O_IM_RD_DATA), 32'h121300);
      if (p == 7) check_output("lit_pix7_pad", 32'(bus.O_IM_RD_DATA), 32'h000000);
    end
    check_output("lit_pix63",       32'(bus.O_IM_RD_DATA),  32'hBDBEBF);
    check_output("lit_pix63_valid", 32'(bus.O_IM_RD_VALID), 32'd1);
    check_output("lit_drained_full",  32'(bus.O_IM_FULL),   32'd0);
    check_output("lit_drained_empty", 32'(bus.O_IM_EMPTY),  32'd1);

    read_pixel(8'h00, 8'h01, 8'h02);
    check_output("lit_unf",       32'(bus.O_IM_UNF),      32'd1);
    check_output("lit_unf_valid", 32'(bus.O_IM_RD_VALID), 32'd0);

    // Nine scattered beats, then a beat colliding on 0x10, then a flush.
    for (int k = 0; k < 9; k++)
      write_beat($urandom, 8'($urandom_range(100, 196)), 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'hAABB_CCDD, 8'h10, 8'h10, 8'h10, 8'h10,
                   1'b0, 8'h0, 8'h0, 8'h0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
    check_output("lit_clear_empty", 32'(bus.O_IM_EMPTY), 32'd1);
    check_output("lit_clear_unf",   32'(bus.O_IM_UNF),   32'd0);

    for (int k = 0; k < 48; k++) begin
      write_beat($urandom, 8'(64 + 4 * k), 1'b0);
      if (k == 46) check_output("lit_refill_47", 32'(bus.O_IM_FULL), 32'd0);
    end
    check_output("lit_refill_48", 32'(bus.O_IM_FULL), 32'd1);
    read_pixel(8'h10, 8'h10, 8'h10);
    check_output("lit_collision", 32'(bus.O_IM_RD_DATA), 32'hAAAAAA);

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      apply_stimulus($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom,
                     8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 99) == 0);
    end
    reset = 1'b0;
    idle_cycle();
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_imem.md
Name: core_imem

Overview:
- Input pixel buffer between the AHB DMA read path and the rotation core.
- Captures 32-bit AHB read beats into a 256-byte RAM at four per-byte write addresses, driven by the core pixel address generator's IN_ADDR0..3.
- Returns one 24-bit RGB pixel per read at three byte addresses, driven by the generator's IN_ADDRR/G/B.
- Tracks fill/drain of one 8x8-pixel RGB block (192 bytes) and flags protocol errors.

Parameters:
P_DEPTH, 256, RAM depth in bytes (fixed power of two matching the 8-bit address)
P_BLOCK_BEATS, 48, write beats per block (192 bytes / 4)
P_BLOCK_PIXELS, 64, pixel reads per block

Ports:
I_IM_HCLK  in  1  clock
I_IM_RESET  in  1  synchronous reset, active-high
I_IM_CLEAR  in  1  synchronous flush of counters/flags/state; RAM contents kept
I_IM_WR_EN  in  1  write beat valid
I_IM_HRDATA  in  32  beat data; [7:0]->ADDR0, [15:8]->ADDR1, [23:16]->ADDR2, [31:24]->ADDR3
I_IM_WR_ADDR0..3  in  8 each  byte write addresses
I_IM_PAD  in  1  pad beat: write 8'h00 to all four lanes, ignore HRDATA
I_IM_RD_EN  in  1  pixel read request
I_IM_RD_ADDRR/G/B  in  8 each  byte read addresses
O_IM_RD_DATA  out  24  {R,G,B} read data
O_IM_RD_VALID  out  1  RD_DATA valid
O_IM_FULL  out  1  block complete, readable
O_IM_EMPTY  out  1  fill state, no beats written yet
O_IM_OVF  out  1  sticky: write rejected
O_IM_UNF  out  1  sticky: read rejected

Behaviour:
- Reset (and CLEAR): state S_FILL; beat_cnt=0, pix_cnt=0; RD_DATA=24'h0, RD_VALID=0, FULL=0, EMPTY=1, OVF=0, UNF=0. RAM is not reset.
- All decisions use registered state at the start of the cycle. RESET has priority over CLEAR, which has priority over everything else.
- State S_FILL:
  - WR_EN writes four lanes and increments beat_cnt (6-bit).
  - When beat_cnt==P_BLOCK_BEATS-1 and WR_EN, go to S_DRAIN next cycle: FULL=1, beat_cnt=0.
  - RD_EN in S_FILL is rejected: UNF<=1, RD_VALID stays 0.
- State S_DRAIN:
  - RD_EN reads three bytes. RD_DATA/RD_VALID are registered with 1-cycle latency. RD_VALID is a single-cycle pulse per accepted read; RD_DATA holds its value otherwise.
  - pix_cnt (7-bit) increments on each read. When pix_cnt==P_BLOCK_PIXELS-1 and RD_EN, return to S_FILL: FULL=0, EMPTY=1, pix_cnt=0. The last read's data is still delivered one cycle later.
  - WR_EN in S_DRAIN is rejected: RAM unchanged, OVF<=1. This includes the cycle in which the last read occurs.
- EMPTY = S_FILL && beat_cnt==0 (registered).
- Lane collisions: duplicate write addresses in one beat resolve highest lane wins (ADDR3 > ADDR2 > ADDR1 > ADDR0).
- Read-during-write to the same address returns old data. This can only occur through a rejected write, so RAM is unchanged.
- Duplicate read addresses are legal; the same byte is returned in each field.
- Addresses are 8 bits and index the RAM directly; no wrap logic is required.
- OVF/UNF clear only on RESET or CLEAR.
- Reset or CLEAR mid-block: the partial block is abandoned and any in-flight RD_VALID is suppressed next cycle.

Test Plan:
- Reset, then idle -> FULL=0, EMPTY=1, RD_VALID=0, RD_DATA=0, OVF=UNF=0.
- Write 48 beats, beat k = {4k+3,4k+2,4k+1,4k} at addresses 4k..4k+3 -> FULL=1 on the cycle after beat 47, EMPTY=0 after the first beat. Then read R/G/B addresses 0,1,2 -> RD_DATA=24'h000102 with RD_VALID one cycle later.
- Fill block, then issue 64 reads at 3p,3p+1,3p+2 -> pixel p returns {3p,3p+1,3p+2}. FULL falls on the cycle after read 63, whose data/valid appear in that same cycle; EMPTY=1.
- PAD=1 on beat 5 with HRDATA=32'hFFFFFFFF at 20..23 -> reads of bytes 20..23 return 8'h00.
- WR_EN while FULL with HRDATA=32'hDEADBEEF at 0..3 -> OVF=1, byte 0 still reads 8'h00. RD_EN in S_FILL -> UNF=1, no RD_VALID.
- Same beat with all four addresses = 8'h10 and HRDATA=32'hAABBCCDD -> byte 16 reads 8'hAA. CLEAR after 10 beats -> EMPTY=1, beat_cnt restarts, FULL needs 48 further beats.
